// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : Pipeline sequencing controller for the 5-stage core. Detects
//            load-use hazards, taken branches resolved in ID and MDU busy
//            holds, and drives the PC / IF-ID / ID-EX control strobes. Also
//            keeps a saturating 32-bit stall-cycle counter.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   MDU_CYCLES : cycles the MDU stays busy per mult/div (1 .. 2**CNT_W)
//   CNT_W      : MDU countdown width
// Ports:
//   clk             in   rising-edge clock
//   rst             in   asynchronous reset, active-low
//   ID_RS / ID_RT   in   source register fields of the instruction in ID
//   ID_USES_RT      in   ID instruction reads rt
//   EX_MEMREAD      in   instruction in EX is a load
//   EX_RD           in   destination register of the instruction in EX
//   ID_BRANCH_TAKEN in   branch/jump in ID resolved taken
//   ID_MDU_START    in   ID instruction is mult/multu/div/divu
//   ID_MDU_READ     in   ID instruction is mfhi/mflo
//   PC_WR           out  PC write-enable
//   IF_ID_WR        out  IF/ID write-enable
//   IF_ID_FLUSH     out  zero the IF/ID instruction
//   ID_EX_FLUSH     out  insert bubble into ID/EX
//   MDU_BUSY        out  MDU in progress (registered)
//   STALL_CNT       out  saturating stall-cycle counter (registered)
// Configuration macro:
//   BRANCH_DELAY_SLOT_EN : when defined, IF_ID_FLUSH is tied low so the
//                          delay-slot instruction executes.
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int MDU_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ID_RS,
  input  logic [4:0]  ID_RT,
  input  logic        ID_USES_RT,
  input  logic        EX_MEMREAD,
  input  logic [4:0]  EX_RD,
  input  logic        ID_BRANCH_TAKEN,
  input  logic        ID_MDU_START,
  input  logic        ID_MDU_READ,
  output logic        PC_WR,
  output logic        IF_ID_WR,
  output logic        IF_ID_FLUSH,
  output logic        ID_EX_FLUSH,
  output logic        MDU_BUSY,
  output logic [31:0] STALL_CNT
);

  typedef enum logic [0:0] {
    MDU_IDLE = 1'b0,
    MDU_RUN  = 1'b1
  } mdu_state_t;

  // The countdown runs MDU_CYCLES-1 .. 0, giving MDU_CYCLES busy cycles.
  localparam logic [CNT_W-1:0] MDU_LOAD = CNT_W'(MDU_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [31:0]      SAT_MAX  = 32'hFFFF_FFFF;

  mdu_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       stall_cnt_q, stall_cnt_d;

  logic load_use;
  logic mdu_busy;
  logic mdu_hold;
  logic stall;
  logic rs_match;
  logic rt_match;

  // --------------------------------------------------------------------------
  // Hazard detection
  // --------------------------------------------------------------------------
  always_comb begin
    rs_match = (EX_RD == ID_RS);
    rt_match = ID_USES_RT && (EX_RD == ID_RT);
    // r0 is hard-wired zero, so a load targeting it can never feed ID.
    load_use = EX_MEMREAD && (EX_RD != 5'd0) && (rs_match || rt_match);
    mdu_busy = (state_q == MDU_RUN);
    // Both a new mult/div and an mfhi/mflo must wait for the unit to drain.
    mdu_hold = mdu_busy && (ID_MDU_START || ID_MDU_READ);
    stall    = load_use || mdu_hold;
  end

  // --------------------------------------------------------------------------
  // Pipeline control strobes. A stall freezes PC and IF/ID and bubbles ID/EX;
  // a stalled branch is not flushed because it is re-evaluated next cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    PC_WR       = !stall;
    IF_ID_WR    = !stall;
    ID_EX_FLUSH = stall;
`ifdef BRANCH_DELAY_SLOT_EN
    IF_ID_FLUSH = 1'b0;
`else
    IF_ID_FLUSH = ID_BRANCH_TAKEN && !stall;
`endif
  end

  // --------------------------------------------------------------------------
  // MDU busy-window FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= MDU_IDLE;
      cnt_q   <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      MDU_IDLE: begin
        // In IDLE mdu_hold is 0, so stall here can only be a load-use.
        if (ID_MDU_START && !stall) begin
          state_d = MDU_RUN;
          cnt_d   = MDU_LOAD;
        end
      end
      MDU_RUN: begin
        // A start seen in the last busy cycle is held by mdu_hold and is
        // picked up from IDLE on the following cycle: no overlap.
        if (cnt_q == CNT_ZERO) begin
          state_d = MDU_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = MDU_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  assign MDU_BUSY = mdu_busy;

  // --------------------------------------------------------------------------
  // Saturating stall-cycle counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != SAT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  assign STALL_CNT = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Purpose  : Self-checking bench for pipe_hazard_ctrl. A behavioural model
//            tracks remaining MDU busy cycles and the stall count as plain
//            integers; directed sequences are followed by random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  localparam int MDU_CYCLES = 4;
  localparam int CNT_W      = 3;

  logic        clk;
  logic        rst;
  logic [4:0]  id_rs, id_rt, ex_rd;
  logic        id_uses_rt, ex_memread, id_branch_taken, id_mdu_start, id_mdu_read;
  logic        pc_wr, if_id_wr, if_id_flush, id_ex_flush, mdu_busy;
  logic [31:0] stall_cnt;

  int n_cmp;
  int n_err;

  // Model state
  int    mdu_left_m;
  longint stall_cnt_m;

  pipe_hazard_ctrl #(
    .MDU_CYCLES (MDU_CYCLES),
    .CNT_W      (CNT_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .ID_RS           (id_rs),
    .ID_RT           (id_rt),
    .ID_USES_RT      (id_uses_rt),
    .EX_MEMREAD      (ex_memread),
    .EX_RD           (ex_rd),
    .ID_BRANCH_TAKEN (id_branch_taken),
    .ID_MDU_START    (id_mdu_start),
    .ID_MDU_READ     (id_mdu_read),
    .PC_WR           (pc_wr),
    .IF_ID_WR        (if_id_wr),
    .IF_ID_FLUSH     (if_id_flush),
    .ID_EX_FLUSH     (id_ex_flush),
    .MDU_BUSY        (mdu_busy),
    .STALL_CNT       (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                       input logic memrd, input logic [4:0] rd, input logic br,
                       input logic start, input logic rdq);
    id_rs           = rs;
    id_rt           = rt;
    id_uses_rt      = uses_rt;
    ex_memread      = memrd;
    ex_rd           = rd;
    id_branch_taken = br;
    id_mdu_start    = start;
    id_mdu_read     = rdq;
  endtask

  task automatic quiet();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Called at a falling edge with inputs applied: checks every output against
  // the model, then advances the model across the next rising edge and
  // returns at the following falling edge.
  task automatic run_cycle();
    logic lu, hold, st, exp_iff;
    #1;
    lu   = ex_memread && (ex_rd != 5'd0) &&
           ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
    hold = (mdu_left_m > 0) && (id_mdu_start || id_mdu_read);
    st   = lu || hold;
`ifdef BRANCH_DELAY_SLOT_EN
    exp_iff = 1'b0;
`else
    exp_iff = id_branch_taken && !st;
`endif
    check_val("pc_wr",       {31'd0, pc_wr},       {31'd0, !st});
    check_val("if_id_wr",    {31'd0, if_id_wr},    {31'd0, !st});
    check_val("id_ex_flush", {31'd0, id_ex_flush}, {31'd0, st});
    check_val("if_id_flush", {31'd0, if_id_flush}, {31'd0, exp_iff});
    check_val("mdu_busy",    {31'd0, mdu_busy},    {31'd0, (mdu_left_m > 0)});
    check_val("stall_cnt",   stall_cnt,            stall_cnt_m[31:0]);
    @(posedge clk);
    if (rst) begin
      if (st && stall_cnt_m < 64'hFFFF_FFFF) stall_cnt_m++;
      if (mdu_left_m > 0) mdu_left_m--;
      else if (id_mdu_start && !st) mdu_left_m = MDU_CYCLES;
    end
    @(negedge clk);
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    mdu_left_m  = 0;
    stall_cnt_m = 0;
    rst         = 1'b0;
    quiet();

    // Reset with quiet inputs
    repeat (2) @(negedge clk);
    run_cycle();
    rst = 1'b1;
    run_cycle();

    // Load-use on rs: one stall cycle, counter reaches 1
    drive(5'd8, 5'd3, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
    run_cycle();
    quiet();
    run_cycle();
    check_val("stall_cnt_after_lu", stall_cnt, 32'd1);
    // EX_RD == 0 is never a hazard
    drive(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    run_cycle();
    // rt match ignored when rt is not read
    drive(5'd1, 5'd8, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
    run_cycle();
    // rt match honoured when rt is read
    drive(5'd1, 5'd8, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
    run_cycle();

    // MDU start, then mfhi held through the busy window
    drive(5'd2, 5'd3, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    run_cycle();
    check_val("mdu_busy_after_start", {31'd0, mdu_busy}, 32'd1);
    repeat (6) begin
      drive(5'd2, 5'd3, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
      run_cycle();
    end

    // Second start held from the accepting edge onward
    repeat (12) begin
      drive(5'd2, 5'd3, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      run_cycle();
    end
    quiet();
    repeat (5) run_cycle();

    // Load-use coincident with a start while idle: stall wins, start deferred
    drive(5'd9, 5'd3, 1'b0, 1'b1, 5'd9, 1'b0, 1'b1, 1'b0);
    run_cycle();
    drive(5'd9, 5'd3, 1'b0, 1'b0, 5'd9, 1'b0, 1'b1, 1'b0);
    run_cycle();
    quiet();
    repeat (5) run_cycle();

    // Branch without hazard, then branch under load-use
    drive(5'd4, 5'd5, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    run_cycle();
    drive(5'd4, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    run_cycle();

    // Asynchronous reset in the middle of a busy window
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    run_cycle();
    quiet();
    run_cycle();
    #2;
    rst = 1'b0;
    #1;
    check_val("async_rst_busy", {31'd0, mdu_busy}, 32'd0);
    check_val("async_rst_cnt",  stall_cnt,         32'd0);
    mdu_left_m  = 0;
    stall_cnt_m = 0;
    @(negedge clk);
    run_cycle();
    rst = 1'b1;
    run_cycle();

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 9) < 3), 5'($urandom_range(0, 3)),
            ($urandom_range(0, 9) < 2), ($urandom_range(0, 9) < 2),
            ($urandom_range(0, 9) < 2));
      run_cycle();
    end

    // Saturation: preload the counter near its top, then hold a load-use
    drive(5'd7, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
    force dut.stall_cnt_q = 32'hFFFF_FFFD;
    #1;
    release dut.stall_cnt_q;
    stall_cnt_m = 64'hFFFF_FFFD;
    repeat (4) run_cycle();
    check_val("stall_cnt_saturated", stall_cnt, 32'hFFFF_FFFF);
    quiet();
    run_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage core. It drives the write-enable and flush of the IF/ID register, the PC write-enable and the ID/EX bubble insert. It resolves three conditions: load-use hazards, taken branches/jumps resolved in ID, and a multi-cycle multiply/divide unit (MDU) busy window. It also keeps a saturating stall-cycle counter for performance monitoring.

## Interface
Parameters:
- MDU_CYCLES, 32, cycles the MDU stays busy per mult/div; legal range 1..(2^CNT_W)
- CNT_W, 6, MDU countdown width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low
- ID_RS  in  5  rs field of the instruction in ID
- ID_RT  in  5  rt field of the instruction in ID
- ID_USES_RT  in  1  ID instruction reads rt
- EX_MEMREAD  in  1  instruction in EX is a load
- EX_RD  in  5  destination register of the instruction in EX
- ID_BRANCH_TAKEN  in  1  branch/jump in ID resolved taken
- ID_MDU_START  in  1  ID instruction is mult/multu/div/divu
- ID_MDU_READ  in  1  ID instruction is mfhi/mflo
- PC_WR  out  1  PC write-enable
- IF_ID_WR  out  1  IF/ID write-enable
- IF_ID_FLUSH  out  1  zero the IF/ID instruction
- ID_EX_FLUSH  out  1  insert bubble into ID/EX
- MDU_BUSY  out  1  MDU in progress (registered)
- STALL_CNT  out  32  stall cycles since reset, saturating (registered)

## Operation
- load_use = EX_MEMREAD & (EX_RD != 0) & ((EX_RD == ID_RS) | (ID_USES_RT & (EX_RD == ID_RT))).
- mdu_hold = MDU_BUSY & (ID_MDU_START | ID_MDU_READ).
- stall = load_use | mdu_hold.
- stall=1 gives: PC_WR=0, IF_ID_WR=0, ID_EX_FLUSH=1, IF_ID_FLUSH=0.
- stall=0 gives: PC_WR=1, IF_ID_WR=1, ID_EX_FLUSH=0, IF_ID_FLUSH=ID_BRANCH_TAKEN (see Configuration).
- Priority: stall beats flush. A taken branch that is stalled is not flushed. It is re-evaluated on the next cycle.
- MDU FSM states:
  - IDLE → BUSY on ID_MDU_START & !stall & !MDU_BUSY; the count loads MDU_CYCLES-1.
  - In BUSY, the count decrements each cycle.
  - BUSY with count==0 → IDLE at the next edge.
  - MDU_BUSY=1 exactly when the FSM is in BUSY.
- A start in the final BUSY cycle (count==0) is held. It is accepted the following cycle, so there is no back-to-back overlap.
- Non-MDU instructions proceed normally while MDU_BUSY=1.
- STALL_CNT increments on every edge where stall=1. It holds at 0xFFFFFFFF.
- All outputs except MDU_BUSY and STALL_CNT are combinational from the current state and inputs.

## Timing
- Reset (rst=0, asynchronous): FSM=IDLE, count=0, MDU_BUSY=0, STALL_CNT=0.
- With quiet inputs during reset: PC_WR=1, IF_ID_WR=1, both flushes 0.
- Load-use: a single stall cycle. The next edge moves the load to MEM, which clears load_use with no internal state.
- MDU start accepted at edge T: MDU_BUSY=1 for cycles T+1 .. T+MDU_CYCLES, then 0.
- MDU_CYCLES=1: MDU_BUSY is high for exactly one cycle.
- Simultaneous load_use and ID_MDU_START while IDLE: the start is not accepted, and the stall is taken. The start is accepted on the first non-stalled cycle.
- Reset asserted mid-BUSY: the FSM returns to IDLE immediately and MDU_BUSY drops asynchronously.
- Register 0 is never a hazard source (EX_RD==0 gives no stall).

## Configuration
- BRANCH_DELAY_SLOT_EN defined: IF_ID_FLUSH is tied to 0. The delay-slot instruction after a taken branch/jump executes.
- BRANCH_DELAY_SLOT_EN undefined: IF_ID_FLUSH=ID_BRANCH_TAKEN & !stall. The fetched instruction is squashed.

## Test plan
- Reset with rst=0 mid-stream, then release → MDU_BUSY=0, STALL_CNT=0, PC_WR=1, IF_ID_WR=1, flushes 0.
- EX_MEMREAD=1, EX_RD=8, ID_RS=8 → one cycle of PC_WR=0, IF_ID_WR=0, ID_EX_FLUSH=1, STALL_CNT=1. Repeat with EX_RD=0 → no stall. Repeat with ID_RT=8, ID_USES_RT=0 → no stall.
- MDU_CYCLES=4, ID_MDU_START for one cycle → MDU_BUSY high for 4 cycles. ID_MDU_READ during the busy window → stalled until MDU_BUSY falls; STALL_CNT increases per stalled cycle.
- Second ID_MDU_START held from the start edge onward → stalled 4 cycles, accepted on the cycle after MDU_BUSY falls, MDU_BUSY high again for 4 cycles.
- ID_BRANCH_TAKEN=1 with no hazard → IF_ID_FLUSH=1 (macro undefined) or 0 (macro defined). Branch coincident with load_use → IF_ID_FLUSH=0 and the stall is taken.
- Force STALL_CNT near saturation (continuous load_use) → holds at 0xFFFFFFFF.
